// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: elastic AES ShiftRows/InvShiftRows pipeline over LANES 128-bit states.
// Define SHIFT_ROWS_INV_EN to build the inverse mapping selected per beat by iInv.
module shift_rows_pipe #(
   parameter int LANES = 1,
   parameter int STAGES = 2,
   parameter int TAG_W = 4
) (
   input  logic                          iClk,
   input  logic                          iRstn,
   input  logic                          iFlush,
   input  logic                          iValid,
   output logic                          oReady,
   input  logic                          iInv,
   input  logic [TAG_W-1:0]              iTag,
   input  logic [128*LANES-1:0]          iText,
   output logic                          oValid,
   input  logic                          iReady,
   output logic [TAG_W-1:0]              oTag,
   output logic [128*LANES-1:0]          oText,
   output logic [$clog2(STAGES+1)-1:0]   oCount
);
   localparam int W = 128*LANES;
   localparam int CW = $clog2(STAGES+1);
   logic [W-1:0] fwdText, permText;
   logic [STAGES-1:0] vld, load;
   logic [STAGES-1:0][TAG_W-1:0] tag;
   logic [STAGES-1:0][W-1:0] dat;
   logic accept, deliver;
   for (genvar l = 0; l < LANES; l++) begin : gLane
      for (genvar c = 0; c < 4; c++) begin : gCol
         for (genvar r = 0; r < 4; r++) begin : gRow
            assign fwdText[128*l+127-8*(4*c+r) -: 8] = iText[128*l+127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
   end
`ifdef SHIFT_ROWS_INV_EN
   logic [W-1:0] invText;
   for (genvar l = 0; l < LANES; l++) begin : gInvLane
      for (genvar c = 0; c < 4; c++) begin : gInvCol
         for (genvar r = 0; r < 4; r++) begin : gInvRow
            assign invText[128*l+127-8*(4*c+r) -: 8] = iText[128*l+127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
   end
   assign permText = iInv ? invText : fwdText;
`else
   logic unusedInv;
   assign unusedInv = iInv;
   assign permText = fwdText;
`endif
   // a stage loads when any stage from it to the output is empty, or the output drains
   for (genvar s = 0; s < STAGES; s++) begin : gLoad
      assign load[s] = iReady | ~&vld[STAGES-1:s];
   end
   assign oReady = iRstn & ~iFlush & load[0];
   assign accept = iValid & oReady;
   assign deliver = vld[STAGES-1] & iReady;
   assign oValid = vld[STAGES-1];
   assign oTag = tag[STAGES-1];
   assign oText = dat[STAGES-1];
   always_ff @(posedge iClk or negedge iRstn)
      if (!iRstn) begin
         vld <= '0;
         tag <= '0;
         dat <= '0;
         oCount <= '0;
      end else begin
         if (load[0]) begin
            vld[0] <= accept;
            tag[0] <= iTag;
            dat[0] <= permText;
         end
         for (int s = 1; s < STAGES; s++)
            if (load[s]) begin
               vld[s] <= vld[s-1];
               tag[s] <= tag[s-1];
               dat[s] <= dat[s-1];
            end
         if (iFlush) vld <= '0;
         oCount <= iFlush ? '0 : oCount + CW'(accept) - CW'(deliver);
      end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed checks of shift_rows_pipe (LANES=1 and LANES=2, STAGES=2).
module tb_shift_rows_pipe;
   localparam int ST = 2;
`ifdef SHIFT_ROWS_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn, flush, valid, inv, ready, oReady, oValid;
   logic [3:0] tag, oTag;
   logic [127:0] text, oText;
   logic [1:0] oCount;
   logic rstn2, flush2, valid2, inv2, ready2, oReady2, oValid2;
   logic [3:0] tag2, oTag2;
   logic [255:0] text2, oText2;
   logic [1:0] oCount2;
   int total = 0, bad = 0;

   shift_rows_pipe #(.LANES(1), .STAGES(ST), .TAG_W(4)) dut (
      .iClk(clk), .iRstn(rstn), .iFlush(flush), .iValid(valid), .oReady(oReady),
      .iInv(inv), .iTag(tag), .iText(text), .oValid(oValid), .iReady(ready),
      .oTag(oTag), .oText(oText), .oCount(oCount));

   shift_rows_pipe #(.LANES(2), .STAGES(ST), .TAG_W(4)) dut2 (
      .iClk(clk), .iRstn(rstn2), .iFlush(flush2), .iValid(valid2), .oReady(oReady2),
      .iInv(inv2), .iTag(tag2), .iText(text2), .oValid(oValid2), .iReady(ready2),
      .oTag(oTag2), .oText(oText2), .oCount(oCount2));

   function automatic logic [127:0] sr(input logic [127:0] x, input bit i);
      logic [127:0] y;
      y = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            y[127-8*(4*c+r) -: 8] = x[127-8*(4*(i ? (c+4-r)%4 : (c+r)%4)+r) -: 8];
      return y;
   endfunction

   function automatic logic [127:0] pat(input int k);
      return {4{k}} ^ 128'h00112233_44556677_8899aabb_ccddeeff;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [127:0] x, input bit i, input logic [3:0] t,
                           output logic [127:0] got, output logic [3:0] gotTag, output int lat);
      int n;
      valid = 1'b1; text = x; inv = i; tag = t; ready = 1'b1;
      #1;
      n = 0;
      while (!oReady && n < 20) begin tick; n++; end
      total++;
      if (oReady !== 1'b1) begin bad++; $display("FAIL send_accept oReady=%b want=1", oReady); end
      tick;
      valid = 1'b0;
      lat = 1;
      while (!oValid && lat < 20) begin tick; lat++; end
      got = oText;
      gotTag = oTag;
      tick;
   endtask

   task automatic test_reset;
      rstn = 1'b0; rstn2 = 1'b0; flush = 1'b0; flush2 = 1'b0; valid = 1'b0; valid2 = 1'b0;
      inv = 1'b0; inv2 = 1'b0; ready = 1'b0; ready2 = 1'b0; tag = '0; tag2 = '0; text = '0; text2 = '0;
      repeat (2) tick;
      total++; if (oValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", oValid); end
      total++; if (oReady !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", oReady); end
      total++; if (oCount !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", oCount); end
      total++; if (oText !== 128'd0) begin bad++; $display("FAIL rst_text got=%h want=0", oText); end
      rstn = 1'b1;
      #1;
      total++; if (oReady !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", oReady); end
   endtask

   task automatic test_forward;
      logic [127:0] got; logic [3:0] gt; int lat;
      send_one(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h5, got, gt, lat);
      total++; if (got !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin bad++; $display("FAIL fwd_text got=%h want=d4bf5d30e0b452aeb84111f11e2798e5", got); end
      total++; if (gt !== 4'h5) begin bad++; $display("FAIL fwd_tag got=%h want=5", gt); end
      total++; if (lat != ST) begin bad++; $display("FAIL fwd_latency got=%0d want=%0d", lat, ST); end
      total++; if (oCount !== 2'd0) begin bad++; $display("FAIL fwd_count_after got=%0d want=0", oCount); end
   endtask

   task automatic test_inverse;
      logic [127:0] got; logic [3:0] gt; int lat;
`ifdef SHIFT_ROWS_INV_EN
      send_one(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'h1, got, gt, lat);
      total++; if (got !== 128'h000d0a0704010e0b0805020f0c090603) begin bad++; $display("FAIL inv_text got=%h want=000d0a0704010e0b0805020f0c090603", got); end
`endif
      send_one(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'h2, got, gt, lat);
      total++; if (got !== 128'h00050a0f04090e03080d02070c01060b) begin bad++; $display("FAIL fwd2_text got=%h want=00050a0f04090e03080d02070c01060b", got); end
   endtask

   task automatic test_back_pressure;
      int sent, rcv, expCnt; bit sawFull, holding, acc, hs; logic [127:0] held;
      sent = 0; rcv = 0; expCnt = 0; sawFull = 0; holding = 0; held = '0; inv = 1'b0;
      for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
         valid = (sent < 8); text = pat(sent); tag = sent[3:0]; ready = !(cyc >= 3 && cyc <= 7);
         #1;
         total++; if (oCount !== expCnt[1:0]) begin bad++; $display("FAIL bp_count cyc=%0d got=%0d want=%0d", cyc, oCount, expCnt); end
         if (oCount == 2'(ST) && !ready) begin
            sawFull = 1;
            total++; if (oReady !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", cyc, oReady); end
         end
         if (oValid && holding) begin
            total++; if (oText !== held) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, oText, held); end
         end
         holding = oValid && !ready;
         held = oText;
         hs = oValid && ready;
         acc = valid && oReady;
         if (hs) begin
            total++;
            if (oTag !== rcv[3:0] || oText !== sr(pat(rcv), 1'b0)) begin
               bad++; $display("FAIL bp_order got=%h/%h want=%h/%h", oTag, oText, rcv[3:0], sr(pat(rcv), 1'b0));
            end
            rcv++;
         end
         expCnt = expCnt + int'(acc) - int'(hs);
         sent = sent + int'(acc);
         tick;
      end
      valid = 1'b0; ready = 1'b1;
      total++; if (rcv != 8) begin bad++; $display("FAIL bp_all_out got=%0d want=8", rcv); end
      total++; if (!sawFull) begin bad++; $display("FAIL bp_saturate got=0 want=1"); end
   endtask

   task automatic test_mixed;
      logic [127:0] xs [4];
      int sent, rcv, cycles;
      xs[0] = 128'hd42711aee0bf98f1b8b45de51e415230; xs[1] = 128'h000102030405060708090a0b0c0d0e0f;
      xs[2] = 128'h3243f6a8885a308d313198a2e0370734; xs[3] = 128'hffeeddccbbaa99887766554433221100;
      sent = 0; rcv = 0; cycles = 0; ready = 1'b1;
      while (cycles < 20 && rcv < 4) begin
         valid = (sent < 4); text = xs[sent[1:0]]; inv = sent[0]; tag = 4'(sent + 8);
         #1;
         if (oValid) begin
            total++;
            if (oText !== sr(xs[rcv[1:0]], rcv[0] & INV_EN) || oTag !== 4'(rcv + 8)) begin
               bad++; $display("FAIL mix_beat%0d got=%h want=%h", rcv, oText, sr(xs[rcv[1:0]], rcv[0] & INV_EN));
            end
            rcv++;
         end
         sent = sent + int'(valid && oReady);
         cycles++;
         tick;
      end
      valid = 1'b0;
      total++; if (cycles != 4 + ST) begin bad++; $display("FAIL mix_throughput got=%0d want=%0d", cycles, 4 + ST); end
`ifdef SHIFT_ROWS_INV_EN
      begin
         logic [127:0] y, z; logic [3:0] gt; int lat;
         send_one(xs[2], 1'b0, 4'h3, y, gt, lat);
         send_one(y, 1'b1, 4'h4, z, gt, lat);
         total++; if (z !== xs[2]) begin bad++; $display("FAIL mix_roundtrip got=%h want=%h", z, xs[2]); end
      end
`endif
   endtask

   task automatic test_flush;
      logic [127:0] got; logic [3:0] gt; int lat;
      ready = 1'b0; valid = 1'b1; inv = 1'b0; tag = 4'h1; text = pat(20);
      for (int n = 0; n < 10 && oCount != 2'(ST); n++) tick;
      total++; if (oCount !== 2'(ST)) begin bad++; $display("FAIL fl_fill got=%0d want=%0d", oCount, ST); end
      tag = 4'h9; flush = 1'b1;
      #1;
      total++; if (oReady !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b want=0", oReady); end
      tick;
      flush = 1'b0; valid = 1'b0;
      total++; if (oValid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b want=0", oValid); end
      total++; if (oCount !== 2'd0) begin bad++; $display("FAIL fl_count got=%0d want=0", oCount); end
      send_one(pat(21), 1'b0, 4'h3, got, gt, lat);
      total++; if (gt !== 4'h3 || got !== sr(pat(21), 1'b0)) begin bad++; $display("FAIL fl_next got=%h/%h want=3/%h", gt, got, sr(pat(21), 1'b0)); end
      total++; if (lat != ST) begin bad++; $display("FAIL fl_latency got=%0d want=%0d", lat, ST); end
   endtask

   task automatic test_reset_stall;
      logic [127:0] got; logic [3:0] gt; int lat;
      ready = 1'b0; valid = 1'b1; inv = 1'b0; tag = 4'h6; text = pat(30);
      tick;
      valid = 1'b0;
      for (int n = 0; n < 10 && !oValid; n++) tick;
      total++; if (oValid !== 1'b1 || oText !== sr(pat(30), 1'b0)) begin bad++; $display("FAIL rs_held got=%b/%h want=1/%h", oValid, oText, sr(pat(30), 1'b0)); end
      #2 rstn = 1'b0;
      #1;
      total++; if (oValid !== 1'b0 || oTag !== 4'h0) begin bad++; $display("FAIL rs_valid_tag got=%b/%h want=0/0", oValid, oTag); end
      total++; if (oText !== 128'd0) begin bad++; $display("FAIL rs_text got=%h want=0", oText); end
      total++; if (oCount !== 2'd0 || oReady !== 1'b0) begin bad++; $display("FAIL rs_count_ready got=%0d/%b want=0/0", oCount, oReady); end
      tick;
      rstn = 1'b1;
      send_one(pat(31), 1'b0, 4'h7, got, gt, lat);
      total++; if (got !== sr(pat(31), 1'b0) || gt !== 4'h7 || lat != ST) begin bad++; $display("FAIL rs_after got=%h/%h/%0d want=%h/7/%0d", got, gt, lat, sr(pat(31), 1'b0), ST); end
   endtask

   task automatic test_lanes;
      logic [127:0] a, b;
      int lat;
      a = 128'hd42711aee0bf98f1b8b45de51e415230; b = 128'h000102030405060708090a0b0c0d0e0f;
      rstn2 = 1'b1; ready2 = 1'b0; valid2 = 1'b1; tag2 = 4'hc; text2 = {b, a};
      #1;
      total++; if (oReady2 !== 1'b1) begin bad++; $display("FAIL ln_ready got=%b want=1", oReady2); end
      tick;
      valid2 = 1'b0;
      for (int n = 0; n < 10 && !oValid2; n++) tick;
      repeat (2) tick;
      total++; if (oText2 !== {128'h00050a0f04090e03080d02070c01060b, 128'hd4bf5d30e0b452aeb84111f11e2798e5} || oTag2 !== 4'hc) begin
         bad++; $display("FAIL ln_text got=%h/%h", oText2, oTag2);
      end
      #2 rstn2 = 1'b0;
      #1;
      total++; if (oValid2 !== 1'b0 || oText2 !== 256'd0 || oCount2 !== 2'd0 || oTag2 !== 4'h0) begin
         bad++; $display("FAIL ln_reset got=%b/%h/%0d want=0/0/0", oValid2, oText2, oCount2);
      end
      tick;
      rstn2 = 1'b1; ready2 = 1'b1; valid2 = 1'b1; tag2 = 4'hd; text2 = {a, b};
      tick;
      valid2 = 1'b0;
      lat = 1;
      while (!oValid2 && lat < 20) begin tick; lat++; end
      total++; if (oText2 !== {128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h00050a0f04090e03080d02070c01060b} || lat != ST) begin
         bad++; $display("FAIL ln_after got=%h lat=%0d want_lat=%0d", oText2, lat, ST);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_forward;
      test_inverse;
      test_back_pressure;
      test_mixed;
      test_flush;
      test_reset_stall;
      test_lanes;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
